// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: controller commands,
// fetch FSM states and the default reset PC.
package ifu_fetch_pkg;

  typedef logic [1:0] CTRL_Wire_Bus;
  localparam CTRL_Wire_Bus CTRL_STATE_DEFAULT = 2'b00;
  localparam CTRL_Wire_Bus CTRL_STATE_BLOCK   = 2'b01;
  localparam CTRL_Wire_Bus CTRL_STATE_BUBBLE  = 2'b10;
  localparam CTRL_Wire_Bus CTRL_STATE_BRANCH  = 2'b11;

  typedef logic [1:0] IFU_State_Bus;
  localparam IFU_State_Bus IFU_STATE_REQ  = 2'd0;
  localparam IFU_State_Bus IFU_STATE_WAIT = 2'd1;
  localparam IFU_State_Bus IFU_STATE_HOLD = 2'd2;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/ifu_hold_buf.sv
// Holding register for the fetched instruction and its PC; clear wins over
// load, and with neither asserted the contents are held.
module ifu_hold_buf
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_valid
);

  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, runs the icache request/response
// handshake and holds one instruction. Perf counters behind IFU_PERF_CNT_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctrl_signal_pc_i,
  input  logic [ADDR_W-1:0] ctrl_to_pc_new_i,
  output logic              icache_req_valid_o,
  output logic [ADDR_W-1:0] icache_req_addr_o,
  input  logic              icache_req_ready_i,
  input  logic              icache_rsp_valid_i,
  input  logic [INST_W-1:0] icache_rsp_data_i,
  output logic              icache_data_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
);

  IFU_State_Bus      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_target;
  logic              r_kill, w_kill_nxt;
  logic              w_branch, w_default, w_load, w_clr, w_advance;

  assign w_branch  = (ctrl_signal_pc_i == CTRL_STATE_BRANCH);
  assign w_default = (ctrl_signal_pc_i == CTRL_STATE_DEFAULT);
  assign w_target  = ctrl_to_pc_new_i & ~ADDR_W'(3);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IFU_STATE_REQ: begin
        // A request accepted together with a Branch fetches a stale address.
        if (icache_req_ready_i) begin
          w_state_nxt = IFU_STATE_WAIT;
          w_kill_nxt  = w_branch;
        end
      end
      IFU_STATE_WAIT: begin
        if (icache_rsp_valid_i) begin
          w_kill_nxt = 1'b0;
          if (r_kill || w_branch) begin
            w_state_nxt = IFU_STATE_REQ;
          end else begin
            w_state_nxt = IFU_STATE_HOLD;
            w_load      = 1'b1;
          end
        end else if (w_branch) begin
          w_kill_nxt = 1'b1;
        end
      end
      IFU_STATE_HOLD: begin
        if (w_branch) begin
          w_state_nxt = IFU_STATE_REQ;
        end else if (w_default) begin
          w_state_nxt = IFU_STATE_REQ;
          w_pc_nxt    = r_pc + ADDR_W'(4);
          w_advance   = 1'b1;
        end
      end
      default: w_state_nxt = IFU_STATE_REQ;
    endcase
    if (w_branch) w_pc_nxt = w_target;
  end

  assign w_clr = w_branch | w_advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IFU_STATE_REQ;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  ifu_hold_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_load),
    .i_clr   (w_clr),
    .i_pc    (r_pc),
    .i_inst  (icache_rsp_data_i),
    .o_pc    (if_pc_o),
    .o_inst  (if_inst_o),
    .o_valid (if_valid_o)
  );

  assign icache_req_valid_o  = (r_state == IFU_STATE_REQ);
  assign icache_req_addr_o   = r_pc;
  assign icache_data_valid_o = (r_state == IFU_STATE_WAIT) & icache_rsp_valid_i
                             & ~r_kill & ~w_branch;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == IFU_STATE_HOLD) && (ctrl_signal_pc_i == CTRL_STATE_BLOCK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_advance) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`else
  assign perf_fetch_cnt_o = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage that sits directly downstream of the pipeline controller and upstream of the IF/ID register. It owns the architectural PC and obeys `ctrl_signal_pc_o` / `ctrl_to_pc_new_o` from the controller. It runs a request/response handshake with the icache and holds each fetched instruction until the pipeline accepts it. It also returns `icache_data_valid` to the controller.

## Interface
- `ADDR_W`, 64, PC / fetch address width (`AddrBus`)
- `INST_W`, 32, instruction width
- `RESET_PC`, 64'h8000_0000, PC loaded on reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `ctrl_signal_pc_i`  in  2  controller command, `CTRL_STATE_*` encoding
- `ctrl_to_pc_new_i`  in  ADDR_W  redirect target, sampled only on Branch
- `icache_req_valid_o`  out  1  fetch request valid
- `icache_req_addr_o`  out  ADDR_W  fetch address (= PC)
- `icache_req_ready_i`  in  1  icache accepts request this cycle
- `icache_rsp_valid_i`  in  1  icache response valid (one cycle per accepted request)
- `icache_rsp_data_i`  in  INST_W  fetched instruction
- `icache_data_valid_o`  out  1  to controller: non-killed response arriving this cycle
- `if_pc_o`  out  ADDR_W  PC of held instruction
- `if_inst_o`  out  INST_W  held instruction
- `if_valid_o`  out  1  held instruction valid
- `perf_fetch_cnt_o`  out  32  delivered-instruction count (see Configuration)
- `perf_stall_cnt_o`  out  32  cycles in HOLD under Block (see Configuration)

## Operation
- FSM states:
  - REQ: `icache_req_valid_o`=1.
  - WAIT: request accepted, awaiting response.
  - HOLD: `if_valid_o`=1.
- Single-bit `kill_q` marks that the outstanding response must be dropped.
- REQ: `icache_req_ready_i`=1 → WAIT. Otherwise stay; the request is abortable until accepted.
- WAIT, on `icache_rsp_valid_i`:
  - `kill_q`=0: capture data + PC into the hold register → HOLD.
  - `kill_q`=1: drop the response, clear `kill_q` → REQ.
- HOLD: Default → PC <= PC+4, go to REQ. Block or Bubble → stay; the held instruction is stable.
- Block outside HOLD does not stall the icache. A response arriving in WAIT is still captured into HOLD.
- Branch from any state:
  - PC <= `ctrl_to_pc_new_i`; the held instruction is discarded (`if_valid_o`=0 next cycle).
  - REQ with `req_ready_i`=1 in the same cycle → WAIT, `kill_q`=1.
  - REQ without ready → stay in REQ; the new address is presented next cycle.
  - WAIT with no response this cycle → stay in WAIT, `kill_q`=1.
  - WAIT with response this cycle → response dropped, go to REQ.
  - HOLD → REQ.
- PC arithmetic: modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is silent. Bit [1:0] of the redirect target is forced to 0.
- `icache_data_valid_o` = WAIT & `icache_rsp_valid_i` & ~`kill_q` & ~Branch (combinational).
- `icache_rsp_valid_i` is ignored in REQ and HOLD.

## Timing
- Reset values:
  - state=REQ, PC=`RESET_PC`, `kill_q`=0.
  - `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0, counters=0.
  - `icache_req_valid_o`=1 from the first edge after `rst` deasserts.
- Best-case path: request accepted at cycle N, response at N+1, `if_valid_o`=1 at N+2. That gives one instruction per 3 cycles with a zero-wait icache.
- `icache_req_addr_o` changes only in REQ, and only when a Branch or a HOLD→REQ advance occurs.
- Reset asserted mid-operation clears everything immediately. A stale response after reset is ignored because the state is REQ.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - `perf_fetch_cnt_o` increments on each HOLD→REQ via Default.
  - `perf_stall_cnt_o` increments per cycle in HOLD with Block.
  - Both counters are 32-bit wrapping and cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops exist. The port list is identical either way.

## Structure
- Shared package / `defines.v`:
  - `CTRL_STATE_*` encodings and `CTRL_Wire_Bus`.
  - New `IFU_STATE_REQ`, `IFU_STATE_WAIT`, `IFU_STATE_HOLD` (2-bit) and `IFU_State_Bus`.
  - `RESET_PC` default constant.
- Natural sub-module: `ifu_hold_buf`, holding the PC/instruction/valid register with load, clear and hold controls. Everything else stays in `ifu_fetch`.

## Test plan
- Reset release, icache always ready, rsp 1 cycle later, ctrl Default → requests at 0x80000000, 0x80000004, 0x80000008; `if_valid_o` every 3rd cycle.
- Block held 5 cycles while in HOLD with inst 0x00000013 → `if_inst_o`/`if_pc_o` stable for 5 cycles, no new request, `perf_stall_cnt_o`=5 with `IFU_PERF_CNT_EN`.
- Branch to 0x80001002 in WAIT, rsp arrives 2 cycles later → response dropped, `icache_data_valid_o`=0, next request at 0x80001000.
- Branch coinciding with rsp_valid in WAIT → response dropped, next request at the redirect target, `if_valid_o` never asserts for the old PC.
- `icache_req_ready_i` low for 4 cycles, then Branch in REQ → address switches to the target before acceptance; only one request is accepted.
- `rst` pulsed low during WAIT, then a stale rsp_valid → ignored, PC=0x80000000, `if_valid_o`=0.
